// File: rtl/subleq_pkg.sv
// Shared SUBLEQ definitions: state codes used by the control FSM, datapath and pc_incre.
package subleq_pkg;

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        FETCH_A     = 4'd0,
        LOAD_A      = 4'd1,
        FETCH_B     = 4'd2,
        LOAD_B      = 4'd3,
        FETCH_C     = 4'd4,
        LOAD_C      = 4'd5,
        FETCH_MEM_A = 4'd6,
        LOAD_MEM_A  = 4'd7,
        FETCH_MEM_B = 4'd8,
        LOAD_MEM_B  = 4'd9,
        EXECUTE     = 4'd10,
        WRITEBACK   = 4'd11,
        UPDATE_PC   = 4'd12,
        IDLE        = 4'd13,
        HALT        = 4'd14,
        UNUSED      = 4'd15
    } state_t;

endpackage

// File: rtl/subleq_ctrl_fsm.sv
// SUBLEQ control unit: 13-state instruction sequencer with start/halt handshake,
// negative-target halt, retired-instruction counter and optional watchdog.
module subleq_ctrl_fsm
    import subleq_pkg::*;
#(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned MAX_INSTR = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                zero,
    input  logic                negative,
    input  logic [DATA_W-1:0]   mem_data_out,
    output logic [STATE_W-1:0]  state,
    output logic                a_ld,
    output logic                b_ld,
    output logic                c_ld,
    output logic                mem_a_ld,
    output logic                mem_b_ld,
    output logic                result_ld,
    output logic                mem_read,
    output logic                mem_write,
    output logic                pc_ld,
    output logic                busy,
    output logic                halted,
    output logic                timeout,
    output logic [CNT_W-1:0]    instr_count
);

    state_t           cur, nxt;
    logic             c_neg;
    logic             take;
    logic             halt_instr;
    logic             wd_fire;
    logic             restart;
    logic [CNT_W-1:0] cnt_inc;
    logic             unused_data;

    assign take       = zero | negative;
    assign halt_instr = take & c_neg;
    assign cnt_inc    = (&instr_count) ? instr_count : instr_count + 1'b1;
    assign wd_fire    = (MAX_INSTR != 0) && (cnt_inc == CNT_W'(MAX_INSTR)) && !halt_instr;
    assign restart    = ((cur == IDLE) || (cur == HALT)) && start;
    assign state      = cur;

    // Only the sign bit of the target word is consumed here.
    assign unused_data = ^mem_data_out[DATA_W-2:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cur <= IDLE;
        else     cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        case (cur)
            FETCH_A:     nxt = LOAD_A;
            LOAD_A:      nxt = FETCH_B;
            FETCH_B:     nxt = LOAD_B;
            LOAD_B:      nxt = FETCH_C;
            FETCH_C:     nxt = LOAD_C;
            LOAD_C:      nxt = FETCH_MEM_A;
            FETCH_MEM_A: nxt = LOAD_MEM_A;
            LOAD_MEM_A:  nxt = FETCH_MEM_B;
            FETCH_MEM_B: nxt = LOAD_MEM_B;
            LOAD_MEM_B:  nxt = EXECUTE;
            EXECUTE:     nxt = WRITEBACK;
            WRITEBACK:   nxt = UPDATE_PC;
            UPDATE_PC:   nxt = (halt_instr || wd_fire) ? HALT : FETCH_A;
            IDLE, HALT:  if (start) nxt = FETCH_A;
            default:     nxt = IDLE;
        endcase
    end

    always_comb begin
        a_ld      = 1'b0;
        b_ld      = 1'b0;
        c_ld      = 1'b0;
        mem_a_ld  = 1'b0;
        mem_b_ld  = 1'b0;
        result_ld = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        pc_ld     = 1'b0;
        busy      = 1'b0;
        halted    = 1'b0;
        case (cur)
            FETCH_A, FETCH_B, FETCH_C, FETCH_MEM_A, FETCH_MEM_B: begin
                mem_read = 1'b1;
                busy     = 1'b1;
            end
            LOAD_A:     begin mem_read = 1'b1; busy = 1'b1; a_ld     = 1'b1; end
            LOAD_B:     begin mem_read = 1'b1; busy = 1'b1; b_ld     = 1'b1; end
            LOAD_C:     begin mem_read = 1'b1; busy = 1'b1; c_ld     = 1'b1; end
            LOAD_MEM_A: begin mem_read = 1'b1; busy = 1'b1; mem_a_ld = 1'b1; end
            LOAD_MEM_B: begin mem_read = 1'b1; busy = 1'b1; mem_b_ld = 1'b1; end
            EXECUTE:    begin busy = 1'b1; result_ld = 1'b1; end
            WRITEBACK:  begin busy = 1'b1; mem_write = 1'b1; end
            // A watchdog stop still loads the PC; only a halt instruction leaves it in place.
            UPDATE_PC:  begin busy = 1'b1; pc_ld = !halt_instr; end
            HALT:       halted = 1'b1;
            default:    ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_count <= '0;
            timeout     <= 1'b0;
            c_neg       <= 1'b0;
        end else begin
            if (restart) begin
                instr_count <= '0;
                timeout     <= 1'b0;
            end else if (cur == UPDATE_PC) begin
                instr_count <= cnt_inc;
                if (wd_fire) timeout <= 1'b1;
            end
            if (cur == LOAD_C) c_neg <= mem_data_out[DATA_W-1];
        end
    end

endmodule

// File: tb/tb_subleq_ctrl_fsm.sv
// Randomized self-checking bench for subleq_ctrl_fsm against an instruction-level model.
module tb_subleq_ctrl_fsm;

    localparam int unsigned WD = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        zero = 1'b0;
    logic        negative = 1'b0;
    logic [63:0] mem_data_out = '0;
    logic [3:0]  state;
    logic        a_ld, b_ld, c_ld, mem_a_ld, mem_b_ld, result_ld;
    logic        mem_read, mem_write, pc_ld, busy, halted, timeout;
    logic [31:0] instr_count;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Instruction-level model state
    int unsigned m_count = 0;
    bit          m_timeout = 1'b0;
    bit          m_stopped = 1'b0;

    subleq_ctrl_fsm #(.DATA_W(64), .CNT_W(32), .MAX_INSTR(WD)) dut (
        .clk(clk), .rst(rst), .start(start), .zero(zero), .negative(negative),
        .mem_data_out(mem_data_out), .state(state),
        .a_ld(a_ld), .b_ld(b_ld), .c_ld(c_ld), .mem_a_ld(mem_a_ld), .mem_b_ld(mem_b_ld),
        .result_ld(result_ld), .mem_read(mem_read), .mem_write(mem_write), .pc_ld(pc_ld),
        .busy(busy), .halted(halted), .timeout(timeout), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {a_ld,b_ld,c_ld,mem_a_ld,mem_b_ld,result_ld,mem_read,mem_write,busy,halted}
    function automatic logic [9:0] strobes_at_step(input int k);
        return {k == 1, k == 3, k == 5, k == 7, k == 9, k == 10,
                k <= 9, k == 11, 1'b1, 1'b0};
    endfunction

    function automatic logic [9:0] strobes_now();
        return {a_ld, b_ld, c_ld, mem_a_ld, mem_b_ld, result_ld, mem_read, mem_write, busy, halted};
    endfunction

    task automatic check_parked(input string tag, input logic [3:0] exp_state);
        check({tag, "_state"}, state, exp_state);
        check({tag, "_strobes"}, {strobes_now(), pc_ld},
              {9'b0, exp_state == 4'd14, 1'b0});
        check({tag, "_count"}, instr_count, m_count);
        check({tag, "_timeout"}, timeout, m_timeout);
    endtask

    // Entered a little after a falling edge with the DUT parked in IDLE or HALT.
    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_count   = 0;
        m_timeout = 1'b0;
        m_stopped = 1'b0;
        #1;
        check("start_state", state, 4'd0);
        check("start_count", instr_count, 32'd0);
        check("start_timeout", timeout, 1'b0);
        check("start_halted", halted, 1'b0);
    endtask

    // One full instruction with target sign cneg and ALU result res; start toggles randomly.
    task automatic run_instr(input bit cneg, input longint res);
        bit          take, halt_n, wd;
        int unsigned newc;
        take   = (res <= 0);
        halt_n = take && cneg;
        newc   = (m_count == 32'hFFFF_FFFF) ? m_count : m_count + 1;
        wd     = (WD != 0) && (newc == WD) && !halt_n;
        for (int k = 0; k < 13; k++) begin
            start        = 1'($urandom_range(0, 1));
            mem_data_out = {$urandom, $urandom};
            if (k == 5) mem_data_out[63] = cneg;
            if (k >= 10) begin
                zero     = (res == 0);
                negative = (res < 0);
            end else begin
                zero     = 1'($urandom_range(0, 1));
                negative = 1'($urandom_range(0, 1));
            end
            #1;
            check("step_state", state, 64'(k));
            check("step_strobes", strobes_now(), strobes_at_step(k));
            check("step_pc_ld", pc_ld, (k == 12) ? !halt_n : 1'b0);
            @(negedge clk);
        end
        start     = 1'b0;
        m_count   = newc;
        m_timeout = m_timeout | wd;
        m_stopped = halt_n || wd;
        #1;
        check("post_state", state, m_stopped ? 4'd14 : 4'd0);
        check("post_halted", halted, m_stopped);
        check("post_timeout", timeout, m_timeout);
        check("post_count", instr_count, m_count);
    endtask

    initial begin
        // Reset held three cycles, then idle with start low
        repeat (3) @(negedge clk);
        #1;
        check_parked("in_reset", 4'd13);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_parked("idle", 4'd13);

        // Directed: taken non-halting, halt instruction, not-taken with negative target,
        // then watchdog stop on the third retired instruction.
        do_start();
        run_instr(1'b0, 0);
        run_instr(1'b1, -2);
        do_start();
        run_instr(1'b1, 7);
        run_instr(1'b0, 5);
        run_instr(1'b0, -3);
        check("wd_timeout", timeout, 1'b1);
        do_start();
        run_instr(1'b1, 0);

        // Randomized instruction stream
        for (int i = 0; i < 60; i++) begin
            longint res;
            if (m_stopped) do_start();
            case ($urandom_range(0, 3))
                0:       res = -2;
                1:       res = 0;
                2:       res = 7;
                default: res = longint'($signed({$urandom, $urandom}));
            endcase
            run_instr(1'($urandom_range(0, 1)), res);
        end

        // Reset during WRITEBACK with start held high throughout
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_count   = 0;
        m_timeout = 1'b0;
        #1;
        do_start();
        start = 1'b1;
        repeat (11) @(negedge clk);
        #1;
        check("wb_state", state, 4'd11);
        check("wb_mem_write", mem_write, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_mem_write", mem_write, 1'b0);
        check("rst_state", state, 4'd13);
        check("rst_busy", busy, 1'b0);
        check("rst_count", instr_count, 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_parked("post_rst", 4'd13);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
